// File: rtl/register_file_sb.sv
// Multi-read-port register file with pending-write scoreboard; reg 0 hardwired.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.
module register_file_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREAD*AW-1:0]     rsel,
    output logic [NREAD*DATA_W-1:0] rdat,
    output logic [NREAD-1:0]        rbusy,
    input  logic                    WEN,
    input  logic [AW-1:0]           wsel,
    input  logic [DATA_W-1:0]       wdat,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_sel,
    input  logic                    flush,
    output logic [AW:0]             busy_cnt
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              wr_hit;

    assign wr_hit   = !RST && WEN && (wsel != '0);
    assign busy_cnt = cnt_q;

    // Flush wins over everything; issue wins over writeback on the same reg.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (WEN)
                busy_d[wsel] = 1'b0;
            if (iss_en)
                busy_d[iss_sel] = 1'b1;
            busy_d[0] = 1'b0;
        end
        cnt_d = '0;
        for (int k = 0; k < NREGS; k++)
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[k]};
    end

    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rsel[i*AW +: AW] != '0) begin
                rdat[i*DATA_W +: DATA_W] = regs_q[rsel[i*AW +: AW]];
                rbusy[i] = busy_q[rsel[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (wr_hit && (rsel[i*AW +: AW] == wsel)) begin
                    rdat[i*DATA_W +: DATA_W] = wdat;
                    rbusy[i] = !flush && iss_en && (iss_sel == wsel);
                end
`else
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NREGS; k++)
                regs_q[k] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_hit)
                regs_q[wsel] <= wdat;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: driver pushes expected outputs,
// monitor pops and compares them before each rising edge.
module tb_register_file_sb;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 3;
    localparam int AW  = 5;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NRD*AW-1:0]  rsel;
    logic [NRD*DW-1:0]  rdat;
    logic [NRD-1:0]     rbusy;
    logic               WEN;
    logic [AW-1:0]      wsel;
    logic [DW-1:0]      wdat;
    logic               iss_en;
    logic [AW-1:0]      iss_sel;
    logic               flush;
    logic [AW:0]        busy_cnt;

    register_file_sb #(.DATA_W(DW), .NREGS(NR), .NREAD(NRD)) dut (
        .CLK(CLK), .RST(RST), .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
        .WEN(WEN), .wsel(wsel), .wdat(wdat), .iss_en(iss_en),
        .iss_sel(iss_sel), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NRD*DW-1:0] d;
        logic [NRD-1:0]    b;
        logic [AW:0]       c;
        int                cyc;
    } exp_t;

    exp_t         q[$];
    exp_t         m;
    logic [DW-1:0] mem [NR];
    bit           pend[int];
    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;

    // Reference: regs as an array, pending set as an associative set.
    task automatic drive(input bit rst, input bit we, input int ws,
                         input logic [DW-1:0] wd, input bit is,
                         input int isl, input bit fl,
                         input int r0, input int r1, input int r2);
        exp_t e;
        int sel[NRD];
        sel = '{r0, r1, r2};
        @(negedge CLK);
        RST = rst; WEN = we; wsel = ws[AW-1:0]; wdat = wd;
        iss_en = is; iss_sel = isl[AW-1:0]; flush = fl;
        rsel = {sel[2][AW-1:0], sel[1][AW-1:0], sel[0][AW-1:0]};
        for (int i = 0; i < NRD; i++) begin
            logic [DW-1:0] d;
            bit b;
            if (sel[i] == 0) begin
                d = '0; b = 1'b0;
            end else begin
                d = mem[sel[i]];
                b = pend.exists(sel[i]) != 0;
`ifdef REGFILE_BYPASS_EN
                if (!rst && we && ws != 0 && ws == sel[i]) begin
                    d = wd;
                    b = !fl && is && (isl == sel[i]);
                end
`endif
            end
            e.d[i*DW +: DW] = d;
            e.b[i] = b;
        end
        e.c = (AW+1)'(pend.num());
        e.cyc = cyc;
        q.push_back(e);
        if (rst) begin
            foreach (mem[k]) mem[k] = '0;
            pend.delete();
        end else begin
            if (we && ws != 0) mem[ws] = wd;
            if (fl) pend.delete();
            else begin
                if (we && pend.exists(ws)) pend.delete(ws);
                if (is && isl != 0) pend[isl] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int r0, input int r1, input int r2);
        drive(0, 0, 0, '0, 0, 0, 0, r0, r1, r2);
    endtask

    always @(negedge CLK) begin
        #2;
        if (q.size() > 0) begin
            m = q.pop_front();
            checks++;
            if (rdat === m.d) passes++;
            else $display("FAIL rdat cyc %0d got %h exp %h", m.cyc, rdat, m.d);
            checks++;
            if (rbusy === m.b) passes++;
            else $display("FAIL rbusy cyc %0d got %b exp %b", m.cyc, rbusy, m.b);
            checks++;
            if (busy_cnt === m.c) passes++;
            else $display("FAIL busy_cnt cyc %0d got %0d exp %0d", m.cyc, busy_cnt, m.c);
        end
    end

    initial begin
        foreach (mem[k]) mem[k] = '0;
        RST = 1'b1; WEN = 1'b1; wsel = 5; wdat = 32'hDEAD;
        iss_en = 1'b0; iss_sel = '0; flush = 1'b0; rsel = '0;
        repeat (2) @(posedge CLK);

        // reset state, write discarded under reset
        idle(5, 3, 0);
        // write then read
        drive(0, 1, 3, 32'h1234, 0, 0, 0, 3, 3, 5);
        idle(3, 0, 3);
        // register 0
        drive(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        // scoreboard counting
        drive(0, 0, 0, '0, 1, 4, 0, 4, 7, 9);
        drive(0, 0, 0, '0, 1, 7, 0, 4, 7, 9);
        drive(0, 0, 0, '0, 1, 9, 0, 4, 7, 9);
        drive(0, 1, 7, 32'h7777, 0, 0, 0, 7, 4, 9);
        idle(7, 4, 9);
        // simultaneous issue + writeback on a busy register
        drive(0, 0, 0, '0, 1, 6, 0, 6, 0, 0);
        drive(0, 1, 6, 32'h6666, 1, 6, 0, 6, 6, 0);
        idle(6, 6, 4);
        // flush with five busy
        drive(0, 0, 0, '0, 1, 10, 0, 10, 11, 12);
        drive(0, 0, 0, '0, 1, 11, 0, 10, 11, 12);
        drive(0, 1, 13, 32'hF1F1, 1, 12, 1, 12, 13, 4);
        idle(12, 13, 4);
        // reset mid-operation discards same-cycle events
        drive(0, 0, 0, '0, 1, 20, 0, 20, 3, 0);
        drive(1, 1, 21, 32'hBEEF, 1, 22, 0, 20, 21, 3);
        idle(20, 21, 22);

        for (int n = 0; n < 400; n++) begin
            int ws, r[NRD];
            ws = $urandom_range(0, NR-1);
            for (int i = 0; i < NRD; i++)
                r[i] = ($urandom_range(0, 2) == 0) ? ws : $urandom_range(0, NR-1);
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, ws,
                  $urandom, $urandom_range(0, 4) < 2, $urandom_range(0, NR-1),
                  $urandom_range(0, 19) == 0, r[0], r[1], r[2]);
        end
        idle(1, 2, 3);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge CLK);
        @(posedge CLK);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain pending %0d exp 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
